dmem_access: RTL
================

# dmem_access

Multi-cycle data-memory access unit sitting between the datapath's load/store stage and data memory. It narrows datapath stores into byte-lane writes with byte enables and widens memory read words back into 32-bit load results with zero or sign extension. This covers lb/lbu/lh/lhu/lw/sb/sh/sw. A req/ack handshake tolerates a data memory with any number of wait states, and misaligned accesses are trapped before reaching memory.

## Interface
- No parameters. Data width 32, address width 32, little-endian byte lanes.
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  1  start access; sampled only in IDLE
- we  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- sext  in  1  loads only: 1 sign-extend, 0 zero-extend
- addr  in  32  byte address
- wdata  in  32  store data, right-justified
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle completion pulse
- misalign  out  1  valid with done; access was not issued to memory
- rdata  out  32  extended load result; updated only when a load completes
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  32  word address, {addr[31:2],2'b00}
- mem_be  out  4  byte enables (bit i = byte lane i)
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  read word, valid with mem_ack
- mem_ack  in  1  memory completes the request this cycle

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE with req=1 latches we, size, sext, addr, wdata.
  - Misaligned requests go to RESP with misalign set. Misaligned means size=01 with addr[0]=1, size=10 with addr[1:0]≠0, or size=11.
  - All other requests go to ACCESS.
- ACCESS: mem_req=1, and mem_we, mem_addr, mem_be and mem_wdata are stable. On mem_ack, a load captures its lane into rdata and the FSM moves to RESP.
- RESP: done=1 for one cycle, then the FSM returns to IDLE.
- req is ignored while busy=1; it is not queued.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<{addr[1],1'b0}
  - word: 4'b1111
  - loads drive mem_be with the same pattern.
- Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- Load extraction:
  - byte: lane addr[1:0]
  - half: lane addr[1]
  - Extended to 32 bits with the upper bits = sext ? MSB of the extracted field : 0.
- Stores and misaligned accesses leave rdata unchanged.

## Timing
- Reset values: busy=0, done=0, misalign=0, rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0. FSM resets to IDLE.
- All outputs are registered.
- Cycle sequence:
  - req sampled high at edge N.
  - mem_req goes high after edge N.
  - mem_ack is sampled at edge M ≥ N+1.
  - done (and rdata for loads) is high after edge M; the FSM is back in IDLE after edge M+1.
  - With a zero-wait memory (ack in the first ACCESS cycle): 3 cycles request-to-idle, done visible one cycle after the ack cycle.
- Misaligned access: done=misalign=1 after edge N+1, and mem_req never rises.
- mem_ack outside ACCESS is ignored.
- Reset asserted mid-access: all outputs drop to reset values immediately and asynchronously. The memory access is abandoned, and no done is produced.
- req held high continuously: the next request is accepted in the first IDLE cycle after RESP, so throughput is one access per 3 cycles minimum.

## Structure
- Shared control-encoding header `ctrl_encode_def.v` gets:
  - size codes (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`)
  - FSM state encodings.
- One combinational sub-module, `lane_extract`. Inputs: mem_rdata, addr[1:0], size, sext. Output: 32-bit extended load value. It is reusable by any future load path.
- Byte-enable and store-replication logic stays inline.

## Test plan
- Load byte, sign-extended: lb with addr=0x1003, sext=1, mem_rdata=0x80FF_1234, ack after 2 wait cycles. Required: mem_be=1000, rdata=0xFFFF_FF80, done 1 cycle after ack.
- Load byte, zero-extended: same access with sext=0. Required: rdata=0x0000_0080.
- Load halfword: lh with addr=0x2002, sext=1, mem_rdata=0x7FFF_0001. Required: mem_be=1100, rdata=0x0000_7FFF.
- Store byte: sb with addr=0x10, wdata=0xDEAD_BEA5. Required: mem_addr=0x10, mem_be=0001, mem_wdata=0xA5A5_A5A5, mem_we=1, rdata unchanged.
- Store halfword: sh with addr=0x12, wdata=0x0000_C0DE. Required: mem_be=1100, mem_wdata=0xC0DE_C0DE.
- Misaligned word: lw with addr=0x1002. Required: done=misalign=1 two edges after req, mem_req stays 0.
- Reset mid-access: rst_n pulled low during ACCESS. Required: mem_req=0 without waiting for a clock edge, no done. After release, busy=0 and a new access completes normally.

Source files
------------

// File: rtl/dmem_access_pkg.sv
// dmem_access_pkg: shared encodings for the data-memory access unit.
//   - SZ_BYTE / SZ_HALF / SZ_WORD : access size codes carried on 'size'
//   - state_e                     : access FSM state encoding
//   - is_misaligned()             : alignment rule shared by anything that
//                                   needs to know whether an access may issue
package dmem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Size code 2'b11 has no meaning and is trapped like a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = (addr_lo != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_access_lane_extract.sv
// lane_extract: picks the addressed byte/halfword lane out of a 32-bit
// little-endian memory word and zero- or sign-extends it to 32 bits.
// Purely combinational so any load path can reuse it.
//   mem_rdata  in  32  word read from memory
//   addr_lo    in  2   byte offset within the word
//   size       in  2   SZ_BYTE / SZ_HALF / SZ_WORD
//   sext       in  1   1 = sign-extend, 0 = zero-extend
//   load_data  out 32  extended load value
module lane_extract
    import dmem_access_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sext,
    output logic [31:0] load_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = 8'(mem_rdata >> {addr_lo, 3'b000});
        half_v = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size)
            SZ_BYTE: load_data = {{24{sext & byte_v[7]}}, byte_v};
            SZ_HALF: load_data = {{16{sext & half_v[15]}}, half_v};
            default: load_data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/dmem_access.sv
// dmem_access: multi-cycle data-memory access unit between the load/store
// stage and data memory. Narrows stores to byte lanes with byte enables,
// widens loads with zero/sign extension, traps misaligned accesses, and
// waits on mem_ack for any number of memory wait states.
//   clk, rst_n                     clock, async active-low reset
//   req, we, size, sext, addr,
//   wdata                          access request from the datapath
//   busy, done, misalign, rdata    status and load result to the datapath
//   mem_req, mem_we, mem_addr,
//   mem_be, mem_wdata              request to data memory (held until ack)
//   mem_rdata, mem_ack             response from data memory
//
// state  | meaning
// IDLE   | waiting for req; request fields latched when req is seen
// ACCESS | mem_req held with stable address/enables/data until mem_ack
// RESP   | done pulse; a trapped access spends one extra cycle here first
module dmem_access
    import dmem_access_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        misalign,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    state_e      state_q, state_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        misalign_q, misalign_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic [3:0]  be_v;
    logic [31:0] wdata_v;
    logic [31:0] load_data;

    lane_extract u_lane_extract (
        .mem_rdata (mem_rdata),
        .addr_lo   (addr_lo_q),
        .size      (size_q),
        .sext      (sext_q),
        .load_data (load_data)
    );

    always_comb begin
        case (size)
            SZ_BYTE: begin
                be_v    = 4'b0001 << addr[1:0];
                wdata_v = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be_v    = 4'b0011 << {addr[1], 1'b0};
                wdata_v = {2{wdata[15:0]}};
            end
            default: begin
                be_v    = 4'b1111;
                wdata_v = wdata;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        sext_d      = sext_q;
        addr_lo_d   = addr_lo_q;
        done_d      = 1'b0;
        misalign_d  = 1'b0;
        rdata_d     = rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    size_d    = size;
                    sext_d    = sext;
                    addr_lo_d = addr[1:0];
                    if (is_misaligned(size, addr[1:0])) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d     = ST_ACCESS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = we;
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_be_d    = be_v;
                        mem_wdata_d = wdata_v;
                    end
                end
            end
            ST_ACCESS: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = ST_RESP;
                    if (!mem_we_q) begin
                        rdata_d = load_data;
                    end
                end
            end
            ST_RESP: begin
                // A normal completion enters RESP with done already high.
                // done low here means a trapped access whose pulse is due now.
                if (!done_q) begin
                    done_d     = 1'b1;
                    misalign_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            size_q      <= SZ_BYTE;
            sext_q      <= 1'b0;
            addr_lo_q   <= 2'b00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            misalign_q  <= 1'b0;
            rdata_q     <= 32'h0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_be_q    <= 4'h0;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            sext_q      <= sext_d;
            addr_lo_q   <= addr_lo_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            misalign_q  <= misalign_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign misalign  = misalign_q;
    assign rdata     = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule
